// File: rtl/z80_sequencer_param_if.sv
// Control and strobe bundle between the Z80 M/T sequencer and its consumers.
// hold_cycles carries live data only when SEQ_HOLD_STATS_EN is defined.
interface z80_sequencer_param_if #(
  parameter int M_COUNT = 5,
  parameter int T_COUNT = 6,
  parameter int HOLD_N  = 3
);
  logic               nextM;
  logic               setM1;
  logic [HOLD_N-1:0]  hold;
  logic [M_COUNT-1:0] M;
  logic [T_COUNT-1:0] T;
  logic [2:0]         m_num;
  logic [2:0]         t_num;
  logic               timings_en;
  logic               overflow;
  logic [15:0]        hold_cycles;

  modport master (
    output nextM, setM1, hold,
    input  M, T, m_num, t_num, timings_en, overflow, hold_cycles
  );

  modport slave (
    input  nextM, setM1, hold,
    output M, T, m_num, t_num, timings_en, overflow, hold_cycles
  );
endinterface

// File: rtl/z80_sequencer_param.sv
// Parametrised Z80 M-cycle / T-state sequencer with hold stretching and auto M advance.
// Optional SEQ_HOLD_STATS_EN adds a saturating count of held clocks on hold_cycles.
module z80_sequencer_param #(
  parameter int M_COUNT = 5,
  parameter int T_COUNT = 6,
  parameter int HOLD_N  = 3
) (
  input logic                  clk,
  input logic                  reset,
  z80_sequencer_param_if.slave bus
);
  localparam logic [2:0]         M_LAST = 3'(M_COUNT - 1);
  localparam logic [2:0]         T_LAST = 3'(T_COUNT - 1);
  localparam logic [M_COUNT-1:0] M_ONE  = {{(M_COUNT-1){1'b0}}, 1'b1};
  localparam logic [T_COUNT-1:0] T_ONE  = {{(T_COUNT-1){1'b0}}, 1'b1};

  logic               hold_any_s;
  logic [2:0]         m_idx_r;
  logic [2:0]         t_idx_r;
  logic [2:0]         m_inc_s;
  logic [2:0]         m_nxt_s;
  logic [2:0]         t_nxt_s;
  logic               ovf_r;
  logic               ovf_nxt_s;
  logic [M_COUNT-1:0] m_oh_r;
  logic [T_COUNT-1:0] t_oh_r;

  assign hold_any_s = |bus.hold;
  assign m_inc_s    = (m_idx_r == M_LAST) ? 3'd0 : m_idx_r + 3'd1;

  // Next-state selection; a held sequencer keeps every register, overflow included.
  always_comb begin
    m_nxt_s   = m_idx_r;
    t_nxt_s   = t_idx_r;
    ovf_nxt_s = 1'b0;
    if (hold_any_s) begin
      m_nxt_s   = m_idx_r;
      t_nxt_s   = t_idx_r;
      ovf_nxt_s = ovf_r;
    end else if (bus.setM1) begin
      m_nxt_s = 3'd0;
      t_nxt_s = 3'd0;
    end else if (bus.nextM) begin
      m_nxt_s = m_inc_s;
      t_nxt_s = 3'd0;
    end else if (t_idx_r != T_LAST) begin
      t_nxt_s = t_idx_r + 3'd1;
    end else begin
      m_nxt_s   = m_inc_s;
      t_nxt_s   = 3'd0;
      ovf_nxt_s = 1'b1;
    end
  end

  // State and one-hot strobe registers, decoded from the next index so outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_idx_r <= 3'd0;
      t_idx_r <= 3'd0;
      ovf_r   <= 1'b0;
      m_oh_r  <= M_ONE;
      t_oh_r  <= T_ONE;
    end else begin
      m_idx_r <= m_nxt_s;
      t_idx_r <= t_nxt_s;
      ovf_r   <= ovf_nxt_s;
      m_oh_r  <= M_ONE << m_nxt_s;
      t_oh_r  <= T_ONE << t_nxt_s;
    end
  end

  assign bus.M          = m_oh_r;
  assign bus.T          = t_oh_r;
  assign bus.m_num      = m_idx_r;
  assign bus.t_num      = t_idx_r;
  assign bus.overflow   = ovf_r;
  assign bus.timings_en = ~hold_any_s & ~reset;

`ifdef SEQ_HOLD_STATS_EN
  logic [15:0] hold_cnt_r;

  // Saturating count of clocks spent frozen by any hold request.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= 16'h0000;
    end else if (hold_any_s && (hold_cnt_r != 16'hFFFF)) begin
      hold_cnt_r <= hold_cnt_r + 16'h0001;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  assign bus.hold_cycles = hold_cnt_r;
`else
  assign bus.hold_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_z80_sequencer_param.sv
// Directed bench for z80_sequencer_param: default 5x6 instance plus a 5x4 free-running
// instance used to observe T overflow and automatic M advance.
module tb_z80_sequencer_param;
  logic       clk;
  logic       reset;
  logic       auto_mode;
  logic       n_drv;
  logic       s_drv;
  logic [2:0] hold_drv;
  int         checks;
  int         errors;
  int         m;
  int         t;
  int         hs;

  z80_sequencer_param_if #(.M_COUNT(5), .T_COUNT(6), .HOLD_N(3)) bus ();
  z80_sequencer_param_if #(.M_COUNT(5), .T_COUNT(4), .HOLD_N(3)) bus4 ();

  z80_sequencer_param #(.M_COUNT(5), .T_COUNT(6), .HOLD_N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  z80_sequencer_param #(.M_COUNT(5), .T_COUNT(4), .HOLD_N(3)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // In auto mode the controls are derived from the held strobes, as the decode matrix would.
  assign bus.nextM  = auto_mode ? bus.T[5] : n_drv;
  assign bus.setM1  = auto_mode ? (bus.M[4] & bus.T[5]) : s_drv;
  assign bus.hold   = hold_drv;
  assign bus4.nextM = 1'b0;
  assign bus4.setM1 = 1'b0;
  assign bus4.hold  = 3'b000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp6(input int mi, input int ti, input logic o);
    logic [4:0] mo;
    logic [5:0] to;
    mo = 5'b00001 << mi;
    to = 6'b000001 << ti;
    return {14'd0, mo, to, 3'(mi), 3'(ti), o};
  endfunction

  function automatic logic [31:0] obs6();
    return {14'd0, bus.M, bus.T, bus.m_num, bus.t_num, bus.overflow};
  endfunction

  function automatic logic [31:0] exp4(input int mi, input int ti, input logic o);
    logic [4:0] mo;
    logic [3:0] to;
    mo = 5'b00001 << mi;
    to = 4'b0001 << ti;
    return {16'd0, mo, to, 3'(mi), 3'(ti), o};
  endfunction

  function automatic logic [31:0] obs4();
    return {16'd0, bus4.M, bus4.T, bus4.m_num, bus4.t_num, bus4.overflow};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
`ifdef SEQ_HOLD_STATS_EN
    hs = 1;
`else
    hs = 0;
`endif
    reset     = 1'b1;
    auto_mode = 1'b0;
    n_drv     = 1'b0;
    s_drv     = 1'b0;
    hold_drv  = 3'b000;

    // Reset held three clocks
    repeat (3) step();
    check("rst_ten", 32'(bus.timings_en), 32'd0);
    check("rst_state", obs6(), exp6(0, 0, 1'b0));
    check("rst_hc", 32'(bus.hold_cycles), 32'd0);
    check("rst_state4", obs4(), exp4(0, 0, 1'b0));
    reset     = 1'b0;
    auto_mode = 1'b1;
    #1;
    check("ten_on", 32'(bus.timings_en), 32'd1);

    // Free run 30 clocks; the 5x4 instance overflows every 4th clock
    m = 0;
    t = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (t == 5) begin
        t = 0;
        m = (m == 4) ? 0 : m + 1;
      end else begin
        t = t + 1;
      end
      check("free_run", obs6(), exp6(m, t, 1'b0));
      check("ovf4_run", obs4(), exp4((k / 4) % 5, k % 4, (k % 4) == 0));
      if (k == 4) check("ovf4_first", obs4(), exp4(1, 0, 1'b1));
      if (k == 5) check("ovf4_drop", obs4(), exp4(1, 1, 1'b0));
      if (k == 20) check("ovf4_wrap", obs4(), exp4(0, 0, 1'b1));
    end
    check("free_wrap", obs6(), exp6(0, 0, 1'b0));

    // Walk to M2/T3, then hold for 4 clocks
    repeat (8) step();
    check("pre_hold", obs6(), exp6(1, 2, 1'b0));
    hold_drv = 3'b010;
    #1;
    check("hold_ten", 32'(bus.timings_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_frz", obs6(), exp6(1, 2, 1'b0));
    end
    check("hold_cnt", 32'(bus.hold_cycles), 32'(4 * hs));
    hold_drv = 3'b000;
    step();
    check("hold_rel", obs6(), exp6(1, 3, 1'b0));

    // Manual control: nextM into M3, then T2
    auto_mode = 1'b0;
    n_drv     = 1'b1;
    step();
    check("nextm", obs6(), exp6(2, 0, 1'b0));
    n_drv = 1'b0;
    step();
    check("m3t2", obs6(), exp6(2, 1, 1'b0));

    // setM1+nextM under hold, then without hold
    n_drv    = 1'b1;
    s_drv    = 1'b1;
    hold_drv = 3'b001;
    step();
    check("prio_hold", obs6(), exp6(2, 1, 1'b0));
    hold_drv = 3'b000;
    step();
    check("prio_set", obs6(), exp6(0, 0, 1'b0));

    // nextM to M4, then T5, then reset during hold
    s_drv = 1'b0;
    repeat (3) step();
    check("to_m4", obs6(), exp6(3, 0, 1'b0));
    n_drv = 1'b0;
    repeat (4) step();
    check("m4t5", obs6(), exp6(3, 4, 1'b0));
    hold_drv = 3'b100;
    repeat (2) step();
    check("hold2_frz", obs6(), exp6(3, 4, 1'b0));
    check("hold_cnt2", 32'(bus.hold_cycles), 32'(7 * hs));
    reset = 1'b1;
    step();
    check("rst_hold", obs6(), exp6(0, 0, 1'b0));
    check("rst_hold_hc", 32'(bus.hold_cycles), 32'd0);
    check("rst_hold_ten", 32'(bus.timings_en), 32'd0);
    reset    = 1'b0;
    hold_drv = 3'b000;
    step();
    check("post_rst", obs6(), exp6(0, 1, 1'b0));

    // nextM wraps from M5 back to M1
    n_drv = 1'b1;
    repeat (4) step();
    check("to_m5", obs6(), exp6(4, 0, 1'b0));
    step();
    check("nextm_wrap", obs6(), exp6(0, 0, 1'b0));
    n_drv = 1'b0;
    check("dut4_ten", 32'(bus4.timings_en), 32'd1);
    check("dut4_hc", 32'(bus4.hold_cycles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
